// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the shared-ALU arbiter: two request/operand ports and a shared response.
interface alu_arbiter_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned OPW = 4
);
  logic           Req0;
  logic           Req1;
  logic [OPW-1:0] Op0;
  logic [OPW-1:0] Op1;
  logic [DW-1:0]  A0;
  logic [DW-1:0]  A1;
  logic [DW-1:0]  B0;
  logic [DW-1:0]  B1;
  logic           Gnt0;
  logic           Gnt1;
  logic           RspValid0;
  logic           RspValid1;
  logic           RspReady0;
  logic           RspReady1;
  logic [DW-1:0]  Result;
  logic           ZeroOut;

  modport master (
    output Req0, Req1, Op0, Op1, A0, A1, B0, B1, RspReady0, RspReady1,
    input  Gnt0, Gnt1, RspValid0, RspValid1, Result, ZeroOut
  );

  modport slave (
    input  Req0, Req1, Op0, Op1, A0, A1, B0, B1, RspReady0, RspReady1,
    output Gnt0, Gnt1, RspValid0, RspValid1, Result, ZeroOut
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the core datapath (0) and the
// auxiliary sequencer (1); one operation in flight, result returned over valid/ready.
module alu_arbiter #(
  parameter int unsigned    DW     = 8,
  parameter int unsigned    OPW    = 4,
  parameter logic [OPW-1:0] NOP_OP = OPW'(4'hF)
) (
  input  logic           Clk,
  input  logic           Reset_n,
  alu_arbiter_if.slave   bus,
  output logic [DW-1:0]  AluA,
  output logic [DW-1:0]  AluB,
  output logic [OPW-1:0] AluOp,
  input  logic [DW-1:0]  AluOut,
  input  logic           AluZero,
  output logic           Busy,
  output logic [7:0]     OpCount
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_owner;
  logic           r_last_gnt;
  logic [OPW-1:0] r_op;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic [DW-1:0]  r_result;
  logic           r_zero;
  logic [CW-1:0]  r_op_count;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_done;
  logic           w_ready;

  // Next state and grant decode; on a tie the requester not granted last time wins.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_done      = 1'b0;
    w_ready     = r_owner ? bus.RspReady1 : bus.RspReady0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.Req0 && (!bus.Req1 || r_last_gnt)) begin
          w_gnt0 = 1'b1;
        end else if (bus.Req1) begin
          w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP: begin
        if (w_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture at grant, result capture at issue, completion count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_owner    <= 1'b0;
      r_last_gnt <= 1'b1;
      r_op       <= NOP_OP;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_gnt0) begin
        r_op       <= bus.Op0;
        r_a        <= bus.A0;
        r_b        <= bus.B0;
        r_owner    <= 1'b0;
        r_last_gnt <= 1'b0;
      end else if (w_gnt1) begin
        r_op       <= bus.Op1;
        r_a        <= bus.A1;
        r_b        <= bus.B1;
        r_owner    <= 1'b1;
        r_last_gnt <= 1'b1;
      end
      if (r_state == S_ISSUE) begin
        r_result <= AluOut;
        r_zero   <= AluZero;
      end
      if (w_done) begin
        r_op_count <= r_op_count + CW'(1);
      end
    end
  end

  assign bus.Gnt0      = w_gnt0;
  assign bus.Gnt1      = w_gnt1;
  assign bus.RspValid0 = (r_state == S_RESP) && !r_owner;
  assign bus.RspValid1 = (r_state == S_RESP) && r_owner;
  assign bus.Result    = r_result;
  assign bus.ZeroOut   = r_zero;

  // Operands stay parked on the ALU; only the opcode is forced to NOP outside issue.
  assign AluA    = r_a;
  assign AluB    = r_b;
  assign AluOp   = (r_state == S_ISSUE) ? r_op : NOP_OP;
  assign Busy    = (r_state != S_IDLE);
  assign OpCount = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and an expected-result scoreboard.
module tb_alu_arbiter;

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;
  localparam logic [3:0] NOP   = 4'hF;
  localparam logic [3:0] K_AND = 4'h0;
  localparam logic [3:0] K_OR  = 4'h1;
  localparam logic [3:0] K_ADD = 4'h2;
  localparam logic [3:0] K_XOR = 4'h3;
  localparam logic [3:0] K_SUB = 4'h6;

  typedef struct packed {
    logic       owner;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] AluA;
  logic [7:0] AluB;
  logic [3:0] AluOp;
  logic [7:0] AluOut;
  logic       AluZero;
  logic       Busy;
  logic [7:0] OpCount;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_cnt = 8'h00;
  logic [3:0] ops[5] = '{K_AND, K_OR, K_ADD, K_XOR, K_SUB};

  alu_arbiter_if #(.DW(DW), .OPW(OPW)) bus ();

  alu_arbiter #(.DW(DW), .OPW(OPW), .NOP_OP(NOP)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus),
    .AluA    (AluA),
    .AluB    (AluB),
    .AluOp   (AluOp),
    .AluOut  (AluOut),
    .AluZero (AluZero),
    .Busy    (Busy),
    .OpCount (OpCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      K_AND:   return a & b;
      K_OR:    return a | b;
      K_ADD:   return a + b;
      K_XOR:   return a ^ b;
      K_SUB:   return a - b;
      default: return 8'h00;
    endcase
  endfunction

  assign AluOut  = alu_f(AluOp, AluA, AluB);
  assign AluZero = (AluOut == 8'h00);

  function automatic exp_t mk(input logic owner, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.owner = owner;
    e.op    = op;
    e.a     = a;
    e.b     = b;
    e.res   = alu_f(op, a, b);
    e.zero  = (e.res == 8'h00);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Sample at the falling edge; push on grant, check ALU drive at issue, pop on handshake.
  task automatic obs();
    @(negedge Clk);
    check("gnt_onehot", 32'(bus.Gnt0 & bus.Gnt1), 32'd0);
    if (bus.Gnt0) q.push_back(mk(1'b0, bus.Op0, bus.A0, bus.B0));
    if (bus.Gnt1) q.push_back(mk(1'b1, bus.Op1, bus.A1, bus.B1));
    if (Busy && !bus.RspValid0 && !bus.RspValid1) begin
      if (q.size() == 0) begin
        check("sb_issue_empty", 32'(q.size()), 32'd1);
      end else begin
        check("issue_alua", 32'(AluA), 32'(q[0].a));
        check("issue_alub", 32'(AluB), 32'(q[0].b));
        check("issue_aluop", 32'(AluOp), 32'(q[0].op));
      end
    end else begin
      check("alu_nop", 32'(AluOp), 32'(NOP));
    end
    if (bus.RspValid0 || bus.RspValid1) begin
      if (q.size() == 0) begin
        check("sb_rsp_empty", 32'(q.size()), 32'd1);
      end else begin
        check("rsp_owner", 32'(bus.RspValid1), 32'(q[0].owner));
        check("rsp_result", 32'(bus.Result), 32'(q[0].res));
        check("rsp_zero", 32'(bus.ZeroOut), 32'(q[0].zero));
        if (q[0].owner ? bus.RspReady1 : bus.RspReady0) begin
          void'(q.pop_front());
          exp_cnt++;
        end
      end
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    bus.Op0 = K_AND; bus.Op1 = K_AND;
    bus.A0 = 8'h00; bus.B0 = 8'h00; bus.A1 = 8'h00; bus.B1 = 8'h00;
    bus.RspReady0 = 1'b0; bus.RspReady1 = 1'b0;

    // Reset values
    repeat (2) @(posedge Clk);
    obs();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_opcount", 32'(OpCount), 32'd0);
    check("rst_aluop", 32'(AluOp), 32'(NOP));
    check("rst_alua", 32'(AluA), 32'd0);
    check("rst_alub", 32'(AluB), 32'd0);
    check("rst_result", 32'(bus.Result), 32'd0);
    check("rst_zero", 32'(bus.ZeroOut), 32'd0);
    check("rst_valid", 32'({bus.RspValid1, bus.RspValid0}), 32'd0);
    check("rst_aluout", 32'(AluOut), 32'd0);
    nxt();
    Reset_n = 1'b1;

    // Reset pulsed during RESP aborts the operation
    bus.Req0 = 1'b1; bus.Op0 = K_ADD; bus.A0 = 8'h05; bus.B0 = 8'h03;
    obs();
    check("abort_gnt0", 32'(bus.Gnt0), 32'd1);
    nxt(); bus.Req0 = 1'b0;
    obs(); nxt();
    obs();
    check("abort_valid", 32'(bus.RspValid0), 32'd1);
    check("abort_result", 32'(bus.Result), 32'h08);
    Reset_n = 1'b0;
    #1;
    check("abort_valid_drop", 32'(bus.RspValid0), 32'd0);
    check("abort_result_drop", 32'(bus.Result), 32'd0);
    check("abort_busy_drop", 32'(Busy), 32'd0);
    check("abort_opcount", 32'(OpCount), 32'd0);
    check("abort_aluop", 32'(AluOp), 32'(NOP));
    q.delete();
    exp_cnt = 8'h00;
    nxt();
    Reset_n = 1'b1;

    // Single ADD from requester 0, ready already high
    bus.Req0 = 1'b1; bus.Op0 = K_ADD; bus.A0 = 8'h05; bus.B0 = 8'h03; bus.RspReady0 = 1'b1;
    obs();
    check("t1_gnt0", 32'(bus.Gnt0), 32'd1);
    check("t1_gnt1", 32'(bus.Gnt1), 32'd0);
    nxt(); bus.Req0 = 1'b0; bus.A0 = 8'hFF; bus.B0 = 8'hFF;
    obs();
    check("t1_busy_issue", 32'(Busy), 32'd1);
    nxt(); obs();
    check("t1_valid0", 32'(bus.RspValid0), 32'd1);
    check("t1_result", 32'(bus.Result), 32'h08);
    check("t1_zero", 32'(bus.ZeroOut), 32'd0);
    nxt(); obs();
    check("t1_busy_done", 32'(Busy), 32'd0);
    check("t1_opcount", 32'(OpCount), 32'd1);
    nxt();

    // Requester 1 XOR held in RESP; non-owner ready ignored
    bus.Req1 = 1'b1; bus.Op1 = K_XOR; bus.A1 = 8'hA5; bus.B1 = 8'hA5; bus.RspReady1 = 1'b0;
    obs();
    check("t2_gnt1", 32'(bus.Gnt1), 32'd1);
    nxt(); bus.Req1 = 1'b0;
    obs(); nxt();
    for (int i = 0; i < 4; i++) begin
      obs();
      check("t2_valid1_held", 32'(bus.RspValid1), 32'd1);
      check("t2_valid0_low", 32'(bus.RspValid0), 32'd0);
      check("t2_result", 32'(bus.Result), 32'h00);
      check("t2_zero", 32'(bus.ZeroOut), 32'd1);
      nxt();
    end
    bus.RspReady1 = 1'b1;
    obs(); nxt();
    obs();
    check("t2_busy_done", 32'(Busy), 32'd0);
    check("t2_opcount", 32'(OpCount), 32'd2);
    nxt();

    // Both requesting continuously: alternate grants every third cycle
    bus.Req0 = 1'b1; bus.Op0 = K_SUB; bus.A0 = 8'h10; bus.B0 = 8'h20;
    bus.Req1 = 1'b1; bus.Op1 = K_OR;  bus.A1 = 8'h00; bus.B1 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      obs();
      check("t3_gnt0", 32'(bus.Gnt0), 32'((i % 3 == 0) && ((i / 3) % 2 == 0)));
      check("t3_gnt1", 32'(bus.Gnt1), 32'((i % 3 == 0) && ((i / 3) % 2 == 1)));
      nxt();
    end
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    obs();
    check("t3_opcount", 32'(OpCount), 32'd6);
    check("t3_opcount_sb", 32'(OpCount), 32'(exp_cnt));
    nxt();

    // Req1 raised during requester 0's issue waits for IDLE; late operand change is ignored
    bus.Req0 = 1'b1; bus.Op0 = K_ADD; bus.A0 = 8'h07; bus.B0 = 8'h09;
    obs();
    check("t4_gnt0", 32'(bus.Gnt0), 32'd1);
    nxt(); bus.Req0 = 1'b0;
    bus.Req1 = 1'b1; bus.Op1 = K_AND; bus.A1 = 8'hF0; bus.B1 = 8'h3C;
    obs();
    check("t4_gnt1_issue", 32'(bus.Gnt1), 32'd0);
    check("t4_busy", 32'(Busy), 32'd1);
    nxt(); obs();
    check("t4_gnt1_resp", 32'(bus.Gnt1), 32'd0);
    check("t4_valid0", 32'(bus.RspValid0), 32'd1);
    check("t4_result0", 32'(bus.Result), 32'h10);
    nxt(); obs();
    check("t4_gnt1_idle", 32'(bus.Gnt1), 32'd1);
    nxt(); bus.Req1 = 1'b0; bus.A1 = 8'h00; bus.B1 = 8'h00;
    obs();
    check("t4_alua", 32'(AluA), 32'hF0);
    check("t4_alub", 32'(AluB), 32'h3C);
    check("t4_aluop", 32'(AluOp), 32'(K_AND));
    nxt(); obs();
    check("t4_valid1", 32'(bus.RspValid1), 32'd1);
    check("t4_result1", 32'(bus.Result), 32'h30);
    nxt(); obs();
    check("t4_opcount", 32'(OpCount), 32'd8);
    nxt();

    // Random operations until the completion counter wraps
    bus.Req0 = 1'b1; bus.RspReady0 = 1'b1;
    for (int i = 0; i < 248; i++) begin
      bus.Op0 = ops[$urandom_range(0, 4)];
      bus.A0  = 8'($urandom);
      bus.B0  = 8'($urandom);
      obs();
      check("t6_gnt0", 32'(bus.Gnt0), 32'd1);
      nxt(); obs();
      nxt(); obs();
      nxt();
    end
    bus.Req0 = 1'b0;
    obs();
    check("t6_opcount_wrap", 32'(OpCount), 32'd0);
    check("t6_opcount_sb", 32'(OpCount), 32'(exp_cnt));
    check("t6_idle_aluop", 32'(AluOp), 32'(NOP));
    check("t6_idle_aluout", 32'(AluOut), 32'd0);
    check("t6_idle_busy", 32'(Busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
